// File: rtl/data_mem_arbiter.sv
// Data memory arbiter: shares one data memory port between the CPU and a loader.
// Registered, state-decoded grants; one memory access per grant cycle.
// Round-robin on conflicts, with an optional loader burst lock of up to MAX_BURST grants.
// Read data returns one cycle after a read grant and is routed by a registered copy
// of the granted port.
// Build option: define DMEM_ARB_FIXED_PRIO_EN to make the CPU always win conflicts.
// In that build ld_lock is ignored and the burst counter is removed.
module data_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_BURST  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  // CPU port
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_stall,
  // Loader port
  input  logic                  ld_req,
  input  logic                  ld_we,
  input  logic                  ld_lock,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_wdata,
  output logic                  ld_gnt,
  output logic                  ld_rvalid,
  output logic [DATA_WIDTH-1:0] ld_rdata,
  // Data memory
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StGntCpu = 2'd1,
    StGntLd  = 2'd2
  } state_e;

  state_e state_q, state_d;

  // 1: the CPU received the most recent grant; 0: the loader did.
  logic last_gnt_cpu_q;
  logic cpu_gnt_q, ld_gnt_q;
  logic cpu_wins;
  logic lock_hold;

  // Read response tracking: set in the cycle after a read grant.
  logic                  cpu_rvalid_q, ld_rvalid_q;
  logic [DATA_WIDTH-1:0] cpu_rdata_q, ld_rdata_q;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  // Lock input has no effect with fixed priority.
  logic unused_ld_lock;
  assign unused_ld_lock = ld_lock;
`else
  localparam logic [7:0] BurstLast = 8'(MAX_BURST - 1);
  logic [7:0] burst_cnt_q;
`endif

  // Arbitration: choose the port to grant in the next cycle.
  always_comb begin
    state_d   = StIdle;
    cpu_wins  = ~last_gnt_cpu_q;
    lock_hold = 1'b0;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    cpu_wins  = 1'b1;
`else
    // A locked loader keeps the port until it has had MAX_BURST consecutive grants.
    lock_hold = (state_q == StGntLd) && ld_lock && ld_req && (burst_cnt_q < BurstLast);
`endif
    if (lock_hold) begin
      state_d = StGntLd;
    end else if (cpu_req && ld_req) begin
      state_d = cpu_wins ? StGntCpu : StGntLd;
    end else if (cpu_req) begin
      state_d = StGntCpu;
    end else if (ld_req) begin
      state_d = StGntLd;
    end else begin
      state_d = StIdle;
    end
  end

  // Grant FSM: state, registered grants, round-robin history and burst count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= StIdle;
      cpu_gnt_q      <= 1'b0;
      ld_gnt_q       <= 1'b0;
      last_gnt_cpu_q <= 1'b0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      burst_cnt_q    <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      cpu_gnt_q <= (state_d == StGntCpu);
      ld_gnt_q  <= (state_d == StGntLd);
      if (state_d != StIdle) begin
        last_gnt_cpu_q <= (state_d == StGntCpu);
      end
`ifndef DMEM_ARB_FIXED_PRIO_EN
      if (state_d != StGntLd) begin
        burst_cnt_q <= 8'd0;
      end else if (lock_hold) begin
        burst_cnt_q <= burst_cnt_q + 8'd1;
      end
`endif
    end
  end

  // Memory request mux: driven from the granted port, all zero when idle.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    if (cpu_gnt_q) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_we    = cpu_we;
      mem_re    = ~cpu_we;
    end else if (ld_gnt_q) begin
      mem_addr  = ld_addr;
      mem_wdata = ld_wdata;
      mem_we    = ld_we;
      mem_re    = ~ld_we;
    end
  end

  // Read response: flag the response cycle per port and keep the last read data.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cpu_rvalid_q <= 1'b0;
      ld_rvalid_q  <= 1'b0;
      cpu_rdata_q  <= '0;
      ld_rdata_q   <= '0;
    end else begin
      cpu_rvalid_q <= cpu_gnt_q & ~cpu_we;
      ld_rvalid_q  <= ld_gnt_q & ~ld_we;
      if (cpu_rvalid_q) begin
        cpu_rdata_q <= mem_rdata;
      end
      if (ld_rvalid_q) begin
        ld_rdata_q <= mem_rdata;
      end
    end
  end

  assign cpu_gnt    = cpu_gnt_q;
  assign ld_gnt     = ld_gnt_q;
  assign cpu_rvalid = cpu_rvalid_q;
  assign ld_rvalid  = ld_rvalid_q;
  // Memory data is valid only in the response cycle, so pass it through then.
  assign cpu_rdata  = cpu_rvalid_q ? mem_rdata : cpu_rdata_q;
  assign ld_rdata   = ld_rvalid_q ? mem_rdata : ld_rdata_q;
  // Writes complete on grant, reads on the returned data.
  assign cpu_stall  = cpu_req & ~(cpu_we ? cpu_gnt_q : cpu_rvalid_q);

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: width of the requester and memory address buses.
REQ-002 Parameter DATA_WIDTH, default 32: width of the write and read data buses.
REQ-003 Parameter MAX_BURST, default 8: maximum number of consecutive loader grants under lock (2..255).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-low reset; takes effect on the rising clk edge while low.
REQ-006 cpu_req / cpu_we  input  1 / 1  CPU access request, write-enable.
REQ-007 cpu_addr / cpu_wdata  input  ADDR_WIDTH / DATA_WIDTH  CPU address, write data.
REQ-008 cpu_gnt / cpu_rvalid  output  1 / 1  CPU access performed this cycle; CPU read data valid.
REQ-009 cpu_rdata  output  DATA_WIDTH  CPU read data.
REQ-010 cpu_stall  output  1  freeze PC/pipeline: cpu_req high and no cpu_rvalid (read) or cpu_gnt (write) yet.
REQ-011 ld_req / ld_we / ld_lock  input  1 / 1 / 1  loader request, write-enable, burst lock.
REQ-012 ld_addr / ld_wdata  input  ADDR_WIDTH / DATA_WIDTH  loader address, write data.
REQ-013 ld_gnt / ld_rvalid / ld_rdata  output  1 / 1 / DATA_WIDTH  loader grant, read valid, read data.
REQ-014 mem_addr / mem_wdata  output  ADDR_WIDTH / DATA_WIDTH  to data memory, driven from the granted port.
REQ-015 mem_we / mem_re  output  1 / 1  memory write/read strobe, high only in a grant cycle.
REQ-016 mem_rdata  input  DATA_WIDTH  memory read data, valid the cycle after mem_re.

Function
REQ-017 FSM states SHALL be IDLE, GNT_CPU, GNT_LD; grants are registered (state-decoded), never combinational from req.
REQ-018 From any state, next state SHALL be GNT_CPU or GNT_LD if the corresponding req is high, else IDLE; one access per grant cycle, back-to-back grants allowed.
REQ-019 When both req high at arbitration, winner SHALL be the port not granted last (last_gnt register, updated on every grant).
REQ-020 In GNT_LD with ld_lock and ld_req high and burst_cnt < MAX_BURST-1, next state SHALL stay GNT_LD regardless of cpu_req; burst_cnt increments per locked grant.
REQ-021 burst_cnt SHALL clear on any transition out of GNT_LD; when burst_cnt reaches MAX_BURST-1 the CPU SHALL win the next arbitration if requesting.
REQ-022 In GNT_x: gnt_x=1, mem_addr/mem_wdata from port x, mem_we=x_we, mem_re=~x_we; in IDLE all mem_* SHALL be 0.
REQ-023 x_rvalid SHALL pulse exactly one cycle after a read grant, with x_rdata = mem_rdata; x_rdata SHALL hold its last value otherwise.
REQ-024 Requesters hold req/addr/we/wdata stable until gnt; a req dropped before grant is discarded with no memory access.
REQ-025 Simultaneous events: a read response and a new grant in the same cycle SHALL both be honoured; rvalid routing uses a registered copy of the granted port.

Reset
REQ-026 While reset is low at a clk edge: state=IDLE, last_gnt=loader (CPU wins first conflict), burst_cnt=0, all gnt/rvalid/mem_we/mem_re=0, rdata outputs=0.
REQ-027 Reset mid-operation SHALL abort any pending read response: no rvalid is issued for a grant whose response cycle coincides with reset.

Configuration
REQ-028 Macro DMEM_ARB_FIXED_PRIO_EN: when defined, CPU SHALL always win conflicts and ld_lock SHALL be ignored (burst_cnt unused); when undefined, round-robin and lock per REQ-019..REQ-021.

Verification
REQ-029 Reset low 2 cycles, then cpu_req read addr 0x10 -> cpu_gnt next cycle, mem_re=1, mem_addr=0x10; cpu_rvalid one cycle later with mem_rdata; cpu_stall high until rvalid.
REQ-030 cpu_req and ld_req both high continuously (no lock) -> grants alternate CPU, LD, CPU, LD starting with CPU after reset.
REQ-031 ld_lock high, ld_req high, cpu_req high, MAX_BURST=8 -> exactly 8 consecutive ld_gnt, then cpu_gnt; with DMEM_ARB_FIXED_PRIO_EN every grant goes to CPU.
REQ-032 ld write 0xDEADBEEF to 0x40 then cpu read 0x40 back-to-back -> mem_we cycle then mem_re cycle, cpu_rdata=0xDEADBEEF.
REQ-033 reset asserted in cycle following a cpu read grant -> no cpu_rvalid, all outputs 0, state IDLE on release.
